// File: rtl/adc_accum_pkg.sv
// adc_accum_pkg: shared widths, FSM state type and frame-length helpers
// for the ADC frame accumulator (adc_frame_accumulator, adc_accum_channel).
package adc_accum_pkg;

    localparam int DATA_W    = 18;
    localparam int SUM_W     = 32;
    localparam int CNT_W     = 13;
    localparam int MAX_SHIFT = 12;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    // Frame length exponents above MAX_SHIFT are treated as MAX_SHIFT.
    function automatic logic [3:0] clamp_shift(input logic [3:0] s);
        return (s > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : s;
    endfunction

    // Number of beats in a frame, 1 .. 4096.
    function automatic logic [CNT_W-1:0] frame_len(input logic [3:0] s);
        return CNT_W'(1) << s;
    endfunction

endpackage

// File: rtl/adc_accum_channel.sv
// adc_accum_channel: per-channel running sum/count (and min/max when
// ADC_ACCUM_MINMAX_EN is defined) for one ADC channel of a frame.
// Ports: clk, rst (sync, active-high); beat = accepted sample beat;
// first = beat is the first of a frame (reloads instead of adding);
// sample_valid/data = this channel's sample; *_nxt = frame value
// including the current beat, sampled by the top on the last beat.
module adc_accum_channel
    import adc_accum_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beat,
    input  logic              first,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data,
`ifdef ADC_ACCUM_MINMAX_EN
    output logic [DATA_W-1:0] min_nxt,
    output logic [DATA_W-1:0] max_nxt,
`endif
    output logic [SUM_W-1:0]  sum_nxt,
    output logic [CNT_W-1:0]  count_nxt
);

    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] count_q;
    logic [SUM_W-1:0] contrib;

    always_comb begin
        contrib = '0;
        if (sample_valid) begin
            contrib = {{(SUM_W-DATA_W){data[DATA_W-1]}}, data};
        end
        sum_nxt   = (first ? SUM_W'(0) : sum_q) + contrib;
        count_nxt = (first ? CNT_W'(0) : count_q) + CNT_W'(sample_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            count_q <= '0;
        end else if (beat) begin
            sum_q   <= sum_nxt;
            count_q <= count_nxt;
        end
    end

`ifdef ADC_ACCUM_MINMAX_EN
    logic signed [DATA_W-1:0] min_q;
    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] sdata;
    logic                     have_prev;

    // A channel with no valid sample yet in the frame reports 0, and the
    // first valid sample seeds both extremes.
    always_comb begin
        sdata     = signed'(data);
        have_prev = !first && (count_q != '0);
        min_nxt   = first ? '0 : min_q;
        max_nxt   = first ? '0 : max_q;
        if (sample_valid) begin
            if (!have_prev || sdata < min_q) begin
                min_nxt = data;
            end
            if (!have_prev || sdata > max_q) begin
                max_nxt = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else if (beat) begin
            min_q <= signed'(min_nxt);
            max_q <= signed'(max_nxt);
        end
    end
`endif

endmodule

// File: rtl/adc_frame_accumulator.sv
// adc_frame_accumulator: sums 2^accum_shift ADC beats per frame, per channel,
// and presents one result per frame on a valid/ready output register.
// Ports: clk, rst (sync, active-high); enable; accum_shift (clamped to 12);
// in_valid/in_ts/in_ch_valid/in_data = ADC beat; out_valid/out_ready
// handshake; out_ts/out_sum/out_count = frame result; dropped_frames
// (saturating). Define ADC_ACCUM_MINMAX_EN to add out_min/out_max.
module adc_frame_accumulator
    import adc_accum_pkg::*;
#(
    parameter int NUM_ADC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [3:0]                accum_shift,
    input  logic                      in_valid,
    input  logic [63:0]               in_ts,
    input  logic [NUM_ADC-1:0]        in_ch_valid,
    input  logic [NUM_ADC*DATA_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_ts,
    output logic [NUM_ADC*SUM_W-1:0]  out_sum,
    output logic [NUM_ADC*CNT_W-1:0]  out_count,
`ifdef ADC_ACCUM_MINMAX_EN
    output logic [NUM_ADC*DATA_W-1:0] out_min,
    output logic [NUM_ADC*DATA_W-1:0] out_max,
`endif
    output logic [15:0]               dropped_frames
);

    state_t state_q;
    state_t state_nxt;

    logic [CNT_W-1:0] beat_cnt_q;
    logic [3:0]       shift_q;
    logic [63:0]      ts_q;

    logic       beat;
    logic       first_beat;
    logic       last_beat;
    logic [3:0] eff_shift;

    logic [NUM_ADC*SUM_W-1:0] sum_nxt;
    logic [NUM_ADC*CNT_W-1:0] count_nxt;
`ifdef ADC_ACCUM_MINMAX_EN
    logic [NUM_ADC*DATA_W-1:0] min_nxt;
    logic [NUM_ADC*DATA_W-1:0] max_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:  if (enable)  state_nxt = ACCUM;
            ACCUM: if (!enable) state_nxt = IDLE;
        endcase
    end

    // The first beat of a frame uses accum_shift directly so a one-beat
    // frame can complete on that same beat; later beats use the latch.
    always_comb begin
        beat       = (state_q == ACCUM) && enable && in_valid;
        first_beat = (beat_cnt_q == '0);
        eff_shift  = first_beat ? clamp_shift(accum_shift) : shift_q;
        last_beat  = beat &&
                     ((beat_cnt_q + CNT_W'(1)) == frame_len(eff_shift));
    end

    for (genvar i = 0; i < NUM_ADC; i++) begin : g_ch
        adc_accum_channel u_ch (
            .clk          (clk),
            .rst          (rst),
            .beat         (beat),
            .first        (first_beat),
            .sample_valid (in_ch_valid[i]),
            .data         (in_data[i*DATA_W +: DATA_W]),
`ifdef ADC_ACCUM_MINMAX_EN
            .min_nxt      (min_nxt[i*DATA_W +: DATA_W]),
            .max_nxt      (max_nxt[i*DATA_W +: DATA_W]),
`endif
            .sum_nxt      (sum_nxt[i*SUM_W +: SUM_W]),
            .count_nxt    (count_nxt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            shift_q    <= '0;
            ts_q       <= '0;
        end else if (state_q == ACCUM && !enable) begin
            beat_cnt_q <= '0;
        end else if (beat) begin
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
            if (first_beat) begin
                shift_q <= eff_shift;
                ts_q    <= in_ts;
            end
        end
    end

    // A completing frame is dropped only if the held result is not being
    // taken this cycle; an accept and a new load may share a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_ts         <= '0;
            out_sum        <= '0;
            out_count      <= '0;
            dropped_frames <= '0;
`ifdef ADC_ACCUM_MINMAX_EN
            out_min        <= '0;
            out_max        <= '0;
`endif
        end else if (last_beat) begin
            if (out_valid && !out_ready) begin
                if (dropped_frames != 16'hFFFF) begin
                    dropped_frames <= dropped_frames + 16'd1;
                end
            end else begin
                out_valid <= 1'b1;
                out_ts    <= first_beat ? in_ts : ts_q;
                out_sum   <= sum_nxt;
                out_count <= count_nxt;
`ifdef ADC_ACCUM_MINMAX_EN
                out_min   <= min_nxt;
                out_max   <= max_nxt;
`endif
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_frame_accumulator.sv
// tb_adc_frame_accumulator: randomized and directed checks of
// adc_frame_accumulator against a frame-level reference model.
module tb_adc_frame_accumulator;

    localparam int NUM = 16;
    localparam int DW  = 18;
    localparam int SW  = 32;
    localparam int CW  = 13;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [3:0]        accum_shift;
    logic              in_valid;
    logic [63:0]       in_ts;
    logic [NUM-1:0]    in_ch_valid;
    logic [NUM*DW-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_ts;
    logic [NUM*SW-1:0] out_sum;
    logic [NUM*CW-1:0] out_count;
    logic [15:0]       dropped_frames;
`ifdef ADC_ACCUM_MINMAX_EN
    logic [NUM*DW-1:0] out_min;
    logic [NUM*DW-1:0] out_max;
`endif

    adc_frame_accumulator #(.NUM_ADC(NUM)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .accum_shift    (accum_shift),
        .in_valid       (in_valid),
        .in_ts          (in_ts),
        .in_ch_valid    (in_ch_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ts         (out_ts),
        .out_sum        (out_sum),
        .out_count      (out_count),
`ifdef ADC_ACCUM_MINMAX_EN
        .out_min        (out_min),
        .out_max        (out_max),
`endif
        .dropped_frames (dropped_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Reference model: a frame is a run of 2^min(shift,12) accepted beats;
    // the result register holds one frame and drops when it cannot take one.
    bit                m_accum;
    int                m_beats;
    int                m_len;
    longint            m_ts;
    longint            m_sum[NUM];
    int                m_cnt[NUM];
    bit                e_valid;
    logic [63:0]       e_ts;
    logic [NUM*SW-1:0] e_sum;
    logic [NUM*CW-1:0] e_count;
    int                e_drops;

    task automatic model_reset();
        m_accum = 0;
        m_beats = 0;
        m_len   = 1;
        m_ts    = 0;
        e_valid = 0;
        e_ts    = '0;
        e_sum   = '0;
        e_count = '0;
        e_drops = 0;
        for (int c = 0; c < NUM; c++) begin
            m_sum[c] = 0;
            m_cnt[c] = 0;
        end
    endtask

    // Advance the model by one clock using the current inputs, then clock
    // the DUT and settle 1 time unit past the edge.
    task automatic step();
        bit     took;
        bit     done;
        longint v;
        int     sh;
        done = 0;
        if (rst) begin
            model_reset();
        end else begin
            took = m_accum && enable && in_valid;
            if (m_accum && !enable) m_beats = 0;
            if (took) begin
                if (m_beats == 0) begin
                    sh    = (accum_shift > 12) ? 12 : int'(accum_shift);
                    m_len = 1 << sh;
                    m_ts  = longint'(in_ts);
                    for (int c = 0; c < NUM; c++) begin
                        m_sum[c] = 0;
                        m_cnt[c] = 0;
                    end
                end
                for (int c = 0; c < NUM; c++) begin
                    if (in_ch_valid[c]) begin
                        v = $signed(in_data[c*DW +: DW]);
                        m_sum[c] += v;
                        m_cnt[c]++;
                    end
                end
                m_beats++;
                if (m_beats == m_len) begin
                    done    = 1;
                    m_beats = 0;
                end
            end
            if (done) begin
                if (e_valid && !out_ready) begin
                    if (e_drops < 65535) e_drops++;
                end else begin
                    e_valid = 1;
                    e_ts    = 64'(m_ts);
                    for (int c = 0; c < NUM; c++) begin
                        e_sum[c*SW +: SW]   = SW'(m_sum[c]);
                        e_count[c*CW +: CW] = CW'(m_cnt[c]);
                    end
                end
            end else if (e_valid && out_ready) begin
                e_valid = 0;
            end
            m_accum = enable;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int val);
        for (int c = 0; c < NUM; c++) in_data[c*DW +: DW] = DW'(val);
    endtask

    task automatic set_rand();
        for (int c = 0; c < NUM; c++) in_data[c*DW +: DW] = DW'($urandom);
        in_ts = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++;
        if (out_valid !== 1'b0 || dropped_frames !== 16'd0)
            $display("FAIL reset_flags: got v=%b d=%0d want v=0 d=0",
                     out_valid, dropped_frames);
        else n_pass++;
        n_total++;
        if (out_sum !== '0 || out_count !== '0 || out_ts !== '0)
            $display("FAIL reset_data: got ts=%h want 0, sum/cnt nonzero=%b",
                     out_ts, (out_sum != '0) || (out_count != '0));
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [63:0] ts0;
        enable      = 1'b1;
        accum_shift = 4'd2;
        out_ready   = 1'b0;
        step();
        in_ch_valid = '1;
        set_all(100);
        in_valid = 1'b1;
        ts0      = 64'h1234_5678_9ABC_0000;
        for (int b = 0; b < 4; b++) begin
            in_ts = ts0 + 64'(b);
            step();
            if (b == 2) begin
                n_total++;
                if (out_valid !== 1'b0)
                    $display("FAIL basic_early: got out_valid=%b want 0",
                             out_valid);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_ts !== ts0)
            $display("FAIL basic_ts: got v=%b ts=%h want v=1 ts=%h",
                     out_valid, out_ts, ts0);
        else n_pass++;
        n_total++;
        if (out_sum !== {NUM{32'd400}} || out_count !== {NUM{13'd4}})
            $display("FAIL basic_sum: got ch0 sum=%0d cnt=%0d want 400/4",
                     $signed(out_sum[SW-1:0]), out_count[CW-1:0]);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL basic_accept: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_partial_valid();
        logic [SW-1:0] s3;
        logic [SW-1:0] s0;
        accum_shift = 4'd1;
        in_ch_valid = '1;
        set_all(-131072);
        in_valid = 1'b1;
        in_ts    = 64'hAAAA;
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL partial_early: got out_valid=%b want 0", out_valid);
        else n_pass++;
        accum_shift    = 4'd0;
        in_ch_valid[3] = 1'b0;
        in_ts          = 64'hBBBB;
        step();
        s3 = out_sum[3*SW +: SW];
        s0 = out_sum[0 +: SW];
        n_total++;
        if (out_valid !== 1'b1 || s3 !== -32'sd131072 ||
            out_count[3*CW +: CW] !== 13'd1)
            $display("FAIL partial_ch3: got v=%b sum=%0d cnt=%0d want 1/-131072/1",
                     out_valid, $signed(s3), out_count[3*CW +: CW]);
        else n_pass++;
        n_total++;
        if (s0 !== -32'sd262144 || out_count[0 +: CW] !== 13'd2 ||
            out_ts !== 64'hAAAA)
            $display("FAIL partial_ch0: got sum=%0d cnt=%0d ts=%h want -262144/2/aaaa",
                     $signed(s0), out_count[0 +: CW], out_ts);
        else n_pass++;
        // shift=0 now applies: one-beat frame while the held result is
        // accepted in the same cycle
        in_ch_valid = '1;
        set_rand();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== e_sum ||
            out_count !== e_count || out_ts !== e_ts ||
            dropped_frames !== 16'd0)
            $display("FAIL swap_load: got v=%b ts=%h d=%0d want v=1 ts=%h d=0",
                     out_valid, out_ts, dropped_frames, e_ts);
        else n_pass++;
        step();
    endtask

    task automatic test_full_scale();
        accum_shift = 4'd12;
        in_ch_valid = '1;
        set_all(131071);
        in_valid = 1'b1;
        for (int b = 0; b < 4096; b++) begin
            in_ts = 64'(b);
            step();
        end
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== {NUM{32'd536866816}} ||
            out_count !== {NUM{13'd4096}})
            $display("FAIL full_scale: got v=%b sum=%0d cnt=%0d want 536866816/4096",
                     out_valid, $signed(out_sum[SW-1:0]), out_count[CW-1:0]);
        else n_pass++;
        // shift 15 must behave as 12
        accum_shift = 4'd15;
        for (int b = 0; b < 4096; b++) begin
            set_rand();
            in_ch_valid = NUM'($urandom);
            step();
            if (b == 4094) begin
                n_total++;
                if (out_valid !== 1'b0)
                    $display("FAIL clamp_early: got out_valid=%b want 0",
                             out_valid);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== e_sum ||
            out_count !== e_count || out_ts !== e_ts)
            $display("FAIL clamp_frame: got v=%b ts=%h cnt0=%0d want v=1 ts=%h cnt0=%0d",
                     out_valid, out_ts, out_count[CW-1:0], e_ts,
                     e_count[CW-1:0]);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [NUM*SW-1:0] s1;
        logic [63:0]       t1;
        out_ready   = 1'b0;
        accum_shift = 4'd0;
        in_valid    = 1'b1;
        in_ch_valid = '1;
        for (int b = 0; b < 3; b++) begin
            set_rand();
            step();
            if (b == 0) begin
                s1 = e_sum;
                t1 = e_ts;
            end
        end
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== s1 || out_ts !== t1 ||
            dropped_frames !== 16'd2)
            $display("FAIL hold_drop: got v=%b ts=%h d=%0d want v=1 ts=%h d=2",
                     out_valid, out_ts, dropped_frames, t1);
        else n_pass++;
        for (int b = 0; b < 65535; b++) step();
        in_valid = 1'b0;
        n_total++;
        if (dropped_frames !== 16'd65535 || e_drops != 65535 ||
            out_sum !== s1)
            $display("FAIL drop_sat: got d=%0d want 65535", dropped_frames);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL drain: got out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_abort();
        accum_shift = 4'd3;
        in_ch_valid = '1;
        set_all(1000);
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) step();
        enable = 1'b0;
        step();
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL abort_out: got out_valid=%b want 0", out_valid);
        else n_pass++;
        in_valid = 1'b0;
        enable   = 1'b1;
        step();
        set_all(7);
        in_valid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            in_ts = 64'h7000 + 64'(b);
            step();
            if (b == 6) begin
                n_total++;
                if (out_valid !== 1'b0)
                    $display("FAIL abort_early: got out_valid=%b want 0",
                             out_valid);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== {NUM{32'd56}} ||
            out_count !== {NUM{13'd8}} || out_ts !== 64'h7000)
            $display("FAIL abort_fresh: got v=%b sum=%0d cnt=%0d ts=%h want 56/8/7000",
                     out_valid, $signed(out_sum[SW-1:0]), out_count[CW-1:0],
                     out_ts);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready   = 1'b0;
        accum_shift = 4'd2;
        in_valid    = 1'b1;
        in_ch_valid = '1;
        for (int b = 0; b < 2; b++) begin
            set_rand();
            step();
        end
        n_total++;
        if (out_valid !== 1'b1)
            $display("FAIL rmid_pending: got out_valid=%b want 1", out_valid);
        else n_pass++;
        rst = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 ||
            out_ts !== '0 || dropped_frames !== 16'd0)
            $display("FAIL rmid_clear: got v=%b ts=%h d=%0d want all 0",
                     out_valid, out_ts, dropped_frames);
        else n_pass++;
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_rand();
            in_ch_valid = NUM'($urandom);
            step();
        end
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_sum !== e_sum ||
            out_count !== e_count || out_ts !== e_ts)
            $display("FAIL rmid_after: got v=%b ts=%h cnt0=%0d want v=1 ts=%h cnt0=%0d",
                     out_valid, out_ts, out_count[CW-1:0], e_ts,
                     e_count[CW-1:0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(39) == 0) enable = ~enable;
            accum_shift = 4'($urandom_range(3));
            in_valid    = ($urandom_range(9) < 7);
            out_ready   = ($urandom_range(2) != 0);
            in_ch_valid = NUM'($urandom);
            set_rand();
            step();
            n_total++;
            if (out_valid !== e_valid ||
                dropped_frames !== 16'(e_drops) ||
                (e_valid && (out_sum !== e_sum || out_count !== e_count ||
                             out_ts !== e_ts))) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_%0d: got v=%b d=%0d ts=%h want v=%b d=%0d ts=%h",
                             i, out_valid, dropped_frames, out_ts,
                             e_valid, e_drops, e_ts);
            end else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        accum_shift = 4'd0;
        in_valid    = 1'b0;
        in_ts       = '0;
        in_ch_valid = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_partial_valid();
        test_full_scale();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
